pc_target_lut: RTL
==================

# pc_target_lut

Programmable branch-target lookup table for the fetch stage. Replaces the fixed 16-entry, ROM-initialised target table with a runtime-writable table of `2**A` entries. Each entry holds either an absolute target or a signed PC-relative offset. A registered lookup port returns the resolved target one cycle after a request. A hardware clear sweep zeroes the table after reset or on demand.

## Interface

**Parameters**
- `D`, 10: PC / target width in bits; all target arithmetic is modulo `2**D`.
- `A`, 4: table address width; depth is `2**A` entries.

**Ports**
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: request a soft clear of the whole table.
- `busy` output 1: high while the clear sweep runs.
- `lu_valid` input 1: lookup request.
- `lu_addr` input A: lookup entry index.
- `pc` input D: PC of the requesting branch, used in relative mode.
- `lu_ready` output 1: lookup can be accepted this cycle.
- `tgt_valid` output 1: `target` holds a fresh result (one-cycle pulse).
- `target` output D: resolved target, registered.
- `wr_en` input 1: table write request.
- `wr_addr` input A: write entry index.
- `wr_data` input D: absolute target, or two's-complement offset.
- `wr_rel` input 1: entry is PC-relative (see Configuration).
- `wr_ready` output 1: write can be accepted this cycle.

## Operation

**State machine:** two states, `CLEAR` and `READY`.
- Reset enters `CLEAR` with the sweep index `clr_idx` = 0.
- In `CLEAR`, one entry is written per cycle: data 0, rel 0, at index `clr_idx`, then the index increments.
- After index `2**A-1` is written, the FSM moves to `READY`. The sweep lasts exactly `2**A` cycles.
- In `READY`, `clr`=1 moves to `CLEAR` with `clr_idx` = 0.
- `clr` is ignored while already in `CLEAR`; the sweep is not restarted.

**Handshake outputs:** `lu_ready` = `wr_ready` = (state == `READY`), and `busy` = (state == `CLEAR`).

**Lookup:**
- Accepted when `lu_valid && lu_ready`.
- For an absolute entry, `target` = entry data.
- For a relative entry, `target` = (`pc` + entry data) mod `2**D`. The offset is a D-bit two's-complement value; the carry out is discarded.
- A lookup issued while `lu_ready`=0 is dropped. It produces no `tgt_valid` and no error.

**Write:**
- Accepted when `wr_en && wr_ready`; updates the entry's data and rel bit at the clock edge.
- Writes issued during `CLEAR` are dropped.

**Simultaneous events:**
- A lookup and a write to the same address in the same cycle is write-first. The result uses the new `wr_data` and `wr_rel`.
- A lookup and a write to different addresses are independent.
- `clr` together with an accepted lookup or write in `READY`: the lookup and write complete, and `CLEAR` starts next cycle. The sweep later zeroes that written entry.
- `tgt_valid` for a lookup accepted on the last `READY` cycle still asserts in the first `CLEAR` cycle.

**Reset:**
- `rst_n` asserted at any time, including mid-sweep or mid-lookup, forces the following immediately: state `CLEAR`, `clr_idx` 0, `tgt_valid` 0, `target` 0.
- Table contents are not reset directly; the following sweep zeroes them.

## Timing

- Reset values:
  - `target` = 0, `tgt_valid` = 0.
  - `lu_ready` = 0, `wr_ready` = 0, `busy` = 1.
- Lookup latency is 1 cycle. If accepted at edge N, `target` and `tgt_valid` are valid after edge N+1.
- Lookup throughput is one per cycle, back-to-back.
- `target` holds its last value when `tgt_valid` = 0.
- After `rst_n` deasserts, `lu_ready` rises after exactly `2**A` rising edges (16 for the defaults).
- `busy` and the ready outputs are decoded from registered state; they have no combinational path from inputs.

## Configuration

Macro `PC_LUT_RELATIVE_EN`:
- **Defined:** a per-entry rel bit and a D-bit adder are compiled in; `wr_rel` selects the mode as described above.
- **Undefined:** no rel storage and no adder. `wr_rel` and `pc` are ignored, every entry is absolute, and `target` = entry data.
- Lookup latency is identical in both builds.

## Structure

- Package `pc_lut_pkg` holds:
  - the state enum typedef `pc_lut_state_t` (`CLEAR`, `READY`);
  - default constants `PC_LUT_D` = 10 and `PC_LUT_A` = 4;
  - the entry struct typedef (data, plus rel when enabled).
- Sub-module `pc_lut_clear_ctl` holds the state register, the sweep counter, and the ready/busy decode.
- The top level holds the table array, write-first bypass, relative adder and output registers.

## Test plan

1. **Reset sweep:** release `rst_n` and count edges. `busy`=1 for 16 cycles, then `lu_ready`=1. A lookup of every address returns `target`=0.
2. **Absolute write/read:** write addr 3 = 0x154 (rel 0), then look up addr 3. On the next cycle, `tgt_valid`=1 and `target`=0x154.
3. **Relative wrap (macro on):**
   - addr 5 = 0x3FF (−1), rel 1, `pc`=4 → 3.
   - addr 6 = 0x3FB (−5), `pc`=2 → 0x3FD.
   - addr 7 = 0x014, `pc`=0x3F0 → 0x004.
4. **Write-first collision:** addr 2 initially holds 0x010. In the same cycle, write addr 2 = 0x0AA and look up addr 2. The result is 0x0AA.
5. **Soft clear with pending lookup:** assert `clr` together with a lookup of addr 3.
   - The lookup result 0x154 appears while `busy`=1.
   - A lookup during the sweep is dropped.
   - After 16 cycles, addr 3 reads 0.
6. **Reset mid-sweep:** assert `rst_n` low at sweep cycle 8 of a soft clear.
   - Outputs return to reset values immediately.
   - After release, a full 16-cycle sweep runs before `lu_ready`.
   - With the macro off, a run of test 3 returns the raw entry data.

Source files
------------

// File: rtl/pc_lut_pkg.sv
// Shared types and default sizes for the programmable branch-target table.
// Build option: define PC_LUT_RELATIVE_EN to add per-entry PC-relative mode.
package pc_lut_pkg;

  localparam int PC_LUT_D = 10;
  localparam int PC_LUT_A = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } pc_lut_state_t;

  // Entry payload is sized by PC_LUT_D; the top-level D parameter must match it.
  typedef struct packed {
`ifdef PC_LUT_RELATIVE_EN
    logic                rel;
`endif
    logic [PC_LUT_D-1:0] data;
  } pc_lut_entry_t;

endpackage

// File: rtl/pc_target_lut_if.sv
// Lookup / write / clear bus of the branch-target table.
// master drives requests (fetch side), slave is the table.
interface pc_target_lut_if
  import pc_lut_pkg::*;
#(
  parameter int D = PC_LUT_D,
  parameter int A = PC_LUT_A
);
  logic         clr;
  logic         busy;
  logic         lu_valid;
  logic [A-1:0] lu_addr;
  logic [D-1:0] pc;
  logic         lu_ready;
  logic         tgt_valid;
  logic [D-1:0] target;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;
  logic         wr_ready;

  modport master (
    output clr, lu_valid, lu_addr, pc, wr_en, wr_addr, wr_data, wr_rel,
    input  busy, lu_ready, tgt_valid, target, wr_ready
  );

  modport slave (
    input  clr, lu_valid, lu_addr, pc, wr_en, wr_addr, wr_data, wr_rel,
    output busy, lu_ready, tgt_valid, target, wr_ready
  );
endinterface

// File: rtl/pc_lut_clear_ctl.sv
// CLEAR/READY controller: walks every table index once after reset or a soft
// clear, then opens the lookup and write ports.
module pc_lut_clear_ctl
  import pc_lut_pkg::*;
#(
  parameter int A = PC_LUT_A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic         busy,
  output logic         ready,
  output logic [A-1:0] sweep_idx
);

  localparam logic [A-1:0] LAST_IDX = '1;

  pc_lut_state_t state_reg, state_next;
  logic [A-1:0]  clr_idx_reg, clr_idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  // A clear request arriving mid-sweep is deliberately ignored.
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    case (state_reg)
      CLEAR: begin
        if (clr_idx_reg == LAST_IDX) begin
          state_next   = READY;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx_reg + A'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_idx_next = '0;
      end
    endcase
  end

  assign busy      = (state_reg == CLEAR);
  assign ready     = (state_reg == READY);
  assign sweep_idx = clr_idx_reg;

endmodule

// File: rtl/pc_target_lut.sv
// Runtime-writable branch-target table with a registered, write-first lookup.
// Build option: PC_LUT_RELATIVE_EN adds the rel bit and the pc + offset adder.
module pc_target_lut
  import pc_lut_pkg::*;
#(
  parameter int D = PC_LUT_D,
  parameter int A = PC_LUT_A
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_target_lut_if.slave    bus
);

  localparam int DEPTH = 1 << A;

  logic          busy;
  logic          ready;
  logic [A-1:0]  sweep_idx;
  logic          lu_acc;
  logic          wr_acc;
  pc_lut_entry_t wr_entry;
  pc_lut_entry_t rd_entry;
  logic [D-1:0]  target_next;
  logic [D-1:0]  target_reg;
  logic          tgt_valid_reg;

  pc_lut_entry_t [DEPTH-1:0] table_q;

  pc_lut_clear_ctl #(.A(A)) u_clear_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .busy      (busy),
    .ready     (ready),
    .sweep_idx (sweep_idx)
  );

  assign lu_acc = bus.lu_valid && ready;
  assign wr_acc = bus.wr_en && ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = bus.wr_data;
`ifdef PC_LUT_RELATIVE_EN
    wr_entry.rel  = bus.wr_rel;
`endif
  end

  // Sweep and user writes never overlap: one needs CLEAR, the other READY.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      pc_lut_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (busy && sweep_idx == A'(gi)) begin
          entry_reg <= '0;
        end else if (wr_acc && bus.wr_addr == A'(gi)) begin
          entry_reg <= wr_entry;
        end
      end

      assign table_q[gi] = entry_reg;
    end
  endgenerate

  // Same-cycle write to the looked-up index bypasses the stored entry.
  always_comb begin
    rd_entry = table_q[bus.lu_addr];
    if (wr_acc && bus.wr_addr == bus.lu_addr) begin
      rd_entry = wr_entry;
    end
`ifdef PC_LUT_RELATIVE_EN
    target_next = rd_entry.rel ? (bus.pc + rd_entry.data) : rd_entry.data;
`else
    target_next = rd_entry.data;
`endif
  end

`ifndef PC_LUT_RELATIVE_EN
  logic unused_rel_inputs;
  assign unused_rel_inputs = ^{bus.pc, bus.wr_rel};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg    <= '0;
      tgt_valid_reg <= 1'b0;
    end else begin
      tgt_valid_reg <= lu_acc;
      if (lu_acc) begin
        target_reg <= target_next;
      end
    end
  end

  assign bus.target    = target_reg;
  assign bus.tgt_valid = tgt_valid_reg;
  assign bus.busy      = busy;
  assign bus.lu_ready  = ready;
  assign bus.wr_ready  = ready;

endmodule
